// File: rtl/apb_master_arb_pkg.sv
// Shared types and constants for the round-robin APB master (apb_master_arb).
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int ADDR_W_DEF      = 8;
    localparam int DATA_W_DEF      = 32;
    localparam int REG_SPACE_BYTES = 16;

    // Word-aligned and inside the register window of the slave.
    function automatic logic addr_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr < 32'(REG_SPACE_BYTES));
    endfunction

endpackage

// File: rtl/apb_master_arb_if.sv
// APB bus bundle between apb_master_arb (master) and the register slave.
interface apb_master_arb_if #(
    parameter int ADDR_W = apb_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = apb_arb_pkg::DATA_W_DEF
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master_arb_rr_arbiter.sv
// Combinational round-robin pick: searches from ptr+1 upward, wrapping.
module apb_rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
)(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // First requester after the pointer wins; later candidates are masked by any.
    always_comb begin
        int   cand_s;
        logic hit_s;
        gnt    = '0;
        idx    = '0;
        any    = 1'b0;
        cand_s = 0;
        hit_s  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand_s      = (int'(ptr) + k) % N;
            hit_s       = req[cand_s] && !any;
            gnt[cand_s] = hit_s;
            idx         = hit_s ? IDX_W'(cand_s) : idx;
            any         = any | hit_s;
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// Round-robin multi-requester APB master. Optional ACCESS-phase abort
// is compiled in with the APB_TIMEOUT_EN macro.
module apb_master_arb
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 16
)(
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    apb_master_arb_if.master          apb
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0]  win_gnt_s;
    logic [IDX_W-1:0]    win_idx_s;
    logic                win_any_s;
    logic                sel_write_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`else
    logic                unused_timeout_cfg_s;
    assign unused_timeout_cfg_s = (TIMEOUT_CYC > 0);
`endif

    apb_rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (win_gnt_s),
        .idx (win_idx_s),
        .any (win_any_s)
    );

    assign sel_write_s = req_write[win_idx_s];
    assign sel_addr_s  = req_addr[win_idx_s*ADDR_W +: ADDR_W];
    assign sel_wdata_s = req_wdata[win_idx_s*DATA_W +: DATA_W];

    // Next-state and next-output logic; outputs are computed one cycle ahead.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        gnt_d       = gnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_any_s) begin
                    gidx_d      = win_idx_s;
                    gnt_d       = win_gnt_s;
                    req_ready_d = win_gnt_s;
                    pwrite_d    = sel_write_s;
                    paddr_d     = sel_addr_s;
                    pwdata_d    = sel_write_s ? sel_wdata_s : '0;
                    if (!addr_legal(32'(sel_addr_s))) begin
                        state_d     = RESP;
                        rsp_valid_d = win_gnt_s;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d   = SETUP;
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (apb.PREADY) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = gnt_q;
                    rsp_rdata_d = pwrite_q ? '0 : apb.PRDATA;
                    rsp_err_d   = apb.PSLVERR;
                end else begin
`ifdef APB_TIMEOUT_EN
                    // PREADY is checked first, so a same-cycle ready beats the abort.
                    if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state_d     = RESP;
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = gnt_q;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`else
                    state_d = ACCESS;
`endif
                end
            end
            RESP: begin
                ptr_d   = gidx_q;
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State, pointer and registered outputs.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            gidx_q      <= '0;
            gnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            gnt_q       <= gnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;
    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Scoreboard bench for apb_master_arb with a four-word APB register slave model.
module tb_apb_master_arb;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        PCLK;
    logic        PRESET;
    logic [1:0]  req_valid_t, req_write_t;
    logic [15:0] req_addr_t;
    logic [63:0] req_wdata_t;
    logic [1:0]  req_ready, rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int          n_tests;
    int          n_fail;
    bit          done;
    int          stall_cfg;
    logic        slverr_cfg;
    int          acc_cnt;
    exp_t        sb_q[$];
    logic [31:0] mem [0:3] = '{32'h1111_1111, 32'hA5A5_A5A5, 32'h3333_3333, 32'h4444_4444};

    apb_master_arb_if #(.ADDR_W(8), .DATA_W(32)) apb ();

    apb_master_arb #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid_t),
        .req_write (req_write_t),
        .req_addr  (req_addr_t),
        .req_wdata (req_wdata_t),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb       (apb)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Slave model: PREADY is held low for stall_cfg ACCESS cycles.
    assign apb.PREADY  = (acc_cnt >= stall_cfg);
    assign apb.PRDATA  = mem[apb.PADDR[3:2]];
    assign apb.PSLVERR = slverr_cfg;

    always @(posedge PCLK) begin
        if (apb.PSEL && apb.PENABLE && !apb.PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (apb.PSEL && apb.PENABLE && apb.PREADY && apb.PWRITE) mem[apb.PADDR[3:2]] <= apb.PWDATA;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int idx, input bit wr, input logic [7:0] addr, input logic [31:0] wd);
        req_write_t[idx]          = wr;
        req_addr_t[idx*8 +: 8]    = addr;
        req_wdata_t[idx*32 +: 32] = wd;
    endtask

    task automatic do_reset();
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
    endtask

    // One isolated transfer with cycle-level phase checks; response goes through the scoreboard.
    task automatic xfer(input int idx, input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                        input bit rej, input logic [31:0] exp_rd, input bit exp_err,
                        input int stall, input bit slverr);
        bit          got;
        int          lat, acc, unstable;
        logic [7:0]  pa0;
        logic [31:0] pw0;
        stall_cfg  = stall;
        slverr_cfg = slverr;
        sb_q.push_back('{idx, exp_rd, exp_err});
        set_req(idx, wr, addr, wd);
        req_valid_t[idx] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge PCLK);
            got = req_ready[idx];
        end
        req_valid_t[idx] = 1'b0;
        chk("accept", 64'(got), 64'd1);
        if (!got) return;
        chk("accept_psel", 64'(apb.PSEL), 64'(!rej));
        chk("accept_penable", 64'(apb.PENABLE), 64'd0);
        pa0 = apb.PADDR;
        pw0 = apb.PWDATA;
        if (!rej) begin
            chk("setup_paddr", 64'(pa0), 64'(addr));
            chk("setup_pwdata", 64'(pw0), 64'(wr ? wd : 32'h0));
        end
        lat = 0; acc = 0; unstable = 0;
        while (!rsp_valid[idx] && lat < 200) begin
            @(negedge PCLK);
            lat++;
            if (apb.PSEL && apb.PENABLE) begin
                acc++;
                if (apb.PADDR !== pa0 || apb.PWDATA !== pw0) unstable++;
            end
        end
        chk("rsp_latency", 64'(lat), 64'(rej ? 0 : 2 + stall));
        chk("access_cycles", 64'(acc), 64'(rej ? 0 : stall + 1));
        chk("access_stable", 64'(unstable), 64'd0);
        chk("resp_psel", 64'(apb.PSEL), 64'd0);
    endtask

    // Requester loop for contention tests: re-issues right after each response.
    task automatic req_loop(input int idx, input int n);
        bit got;
        for (int k = 0; k < n; k++) begin
            req_valid_t[idx] = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 60 && !got; t++) begin
                @(negedge PCLK);
                got = req_ready[idx];
            end
            req_valid_t[idx] = 1'b0;
            chk("loop_accept", 64'(got), 64'd1);
            got = rsp_valid[idx];
            for (int t = 0; t < 60 && !got; t++) begin
                @(negedge PCLK);
                got = rsp_valid[idx];
            end
            chk("loop_rsp", 64'(got), 64'd1);
        end
    endtask

    task automatic monitor();
        exp_t e;
        while (!done) begin
            @(negedge PCLK);
            if (req_ready != 2'b00) chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
            if (rsp_valid != 2'b00) begin
                if (sb_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_valid_idx", 64'(rsp_valid), 64'(2'b01 << e.idx));
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                end
            end
        end
    endtask

    task automatic stimulus();
        bit got;
        int lat;
        PRESET = 1'b1;
        req_valid_t = 2'b00; req_write_t = 2'b00; req_addr_t = '0; req_wdata_t = '0;
        stall_cfg = 0; slverr_cfg = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("rst_psel_penable", 64'({apb.PSEL, apb.PENABLE, apb.PWRITE}), 64'd0);
        chk("rst_paddr_pwdata", 64'({apb.PADDR, apb.PWDATA}), 64'd0);
        chk("rst_req_rsp", 64'({req_ready, rsp_valid, rsp_err}), 64'd0);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        PRESET = 1'b0;

        // Write then read back a word; writes report zero read data.
        xfer(0, 1'b1, 8'h04, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 0, 1'b0);
        xfer(0, 1'b0, 8'h04, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);

        // Contention from reset: grants alternate 0,1,0,1.
        do_reset();
        set_req(0, 1'b0, 8'h00, 32'h0);
        set_req(1, 1'b0, 8'h08, 32'h0);
        sb_q.push_back('{0, 32'h1111_1111, 1'b0});
        sb_q.push_back('{1, 32'h3333_3333, 1'b0});
        sb_q.push_back('{0, 32'h1111_1111, 1'b0});
        sb_q.push_back('{1, 32'h3333_3333, 1'b0});
        fork
            req_loop(0, 2);
            req_loop(1, 2);
        join

        // Rejected addresses never reach the bus.
        xfer(1, 1'b0, 8'h06, 32'h0, 1'b1, 32'h0, 1'b1, 0, 1'b0);
        xfer(0, 1'b1, 8'h10, 32'h1234_5678, 1'b1, 32'h0, 1'b1, 0, 1'b0);

        // Wait states with a slave error at completion.
        xfer(1, 1'b0, 8'h0C, 32'h0, 1'b0, 32'h4444_4444, 1'b1, 5, 1'b1);
        xfer(0, 1'b1, 8'h08, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 3, 1'b0);

        // Reset in the middle of ACCESS.
        stall_cfg = 1000;
        set_req(0, 1'b0, 8'h00, 32'h0);
        req_valid_t[0] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge PCLK);
            got = apb.PENABLE;
            if (req_ready[0]) req_valid_t[0] = 1'b0;
        end
        chk("abort_reached_access", 64'(got), 64'd1);
        #2 PRESET = 1'b1;
        #1;
        chk("abort_psel_penable", 64'({apb.PSEL, apb.PENABLE}), 64'd0);
        chk("abort_paddr_pwdata", 64'({apb.PADDR, apb.PWDATA}), 64'd0);
        chk("abort_req_rsp", 64'({req_ready, rsp_valid}), 64'd0);
        stall_cfg = 0;
        @(negedge PCLK);
        PRESET = 1'b0;
        set_req(0, 1'b0, 8'h00, 32'h0);
        set_req(1, 1'b0, 8'h0C, 32'h0);
        sb_q.push_back('{0, 32'h1111_1111, 1'b0});
        sb_q.push_back('{1, 32'h4444_4444, 1'b0});
        fork
            req_loop(0, 1);
            req_loop(1, 1);
        join

        // Slave that never answers.
        stall_cfg = 100000;
        set_req(0, 1'b0, 8'h08, 32'h0);
        req_valid_t[0] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge PCLK);
            got = req_ready[0];
        end
        req_valid_t[0] = 1'b0;
        chk("stuck_accept", 64'(got), 64'd1);
`ifdef APB_TIMEOUT_EN
        sb_q.push_back('{0, 32'h0, 1'b1});
        lat = 0;
        while (!rsp_valid[0] && lat < 60) begin
            @(negedge PCLK);
            lat++;
        end
        chk("timeout_latency", 64'(lat), 64'd17);
        chk("timeout_psel", 64'({apb.PSEL, apb.PENABLE}), 64'd0);
        stall_cfg = 0;
`else
        sb_q.push_back('{0, 32'hCAFE_F00D, 1'b0});
        repeat (25) @(negedge PCLK);
        chk("stuck_psel_penable", 64'({apb.PSEL, apb.PENABLE}), 64'b11);
        stall_cfg = 0;
        lat = 0;
        while (!rsp_valid[0] && lat < 10) begin
            @(negedge PCLK);
            lat++;
        end
        chk("stuck_release_latency", 64'(lat), 64'd1);
`endif
        repeat (3) @(negedge PCLK);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        done = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        done    = 1'b0;
        fork
            monitor();
            stimulus();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/apb_master_arb.md
Name: apb_master_arb

Overview:
- Multi-requester APB master that shares one APB bus to the 16-byte register slave (four 32-bit words at 0x0, 0x4, 0x8, 0xC) between NUM_REQ requesters.
- Arbitrates round-robin, sequences the APB SETUP/ACCESS phases, waits on PREADY and returns read data and error per requester.
- Sits between the test or control logic and the APB slave.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 8, PADDR / request address width
- DATA_W, 32, PWDATA/PRDATA width
- TIMEOUT_CYC, 16, ACCESS-phase cycles before abort (used only with APB_TIMEOUT_EN)

Ports:
- PCLK  in  1  clock
- PRESET  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request; held until its req_ready
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_ready  out  NUM_REQ  one-cycle accept pulse
- rsp_valid  out  NUM_REQ  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid
- rsp_err  out  1  error, valid with rsp_valid
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

Behaviour:
- All outputs are registered.
- Reset (async, any state including mid-transfer):
  - state=IDLE; all outputs 0; rr pointer = NUM_REQ-1, so requester 0 has first priority.
  - An aborted requester receives no rsp_valid and must re-issue its request.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any req_valid, pick the winner g by round-robin starting at pointer+1 (wrapping).
  - Latch req_write/addr/wdata[g].
  - If req_addr[g][1:0]!=0 or req_addr[g]>=16: go to RESP with error set (no bus cycle).
  - Otherwise go to SETUP.
  - req_ready[g] is high for exactly the first cycle after the accept edge (the SETUP cycle, or the RESP cycle for a rejected request).
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE driven, PWDATA = latched data for writes, 0 for reads. Always one cycle, then ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; address, control and data held stable.
  - Stay until PREADY=1.
  - At the PREADY edge: capture PRDATA (reads only; writes return 0) and PSLVERR, go to RESP.
- RESP:
  - PSEL=PENABLE=0; rsp_valid[g]=1 for one cycle with rsp_rdata and rsp_err.
  - pointer <= g; next state IDLE.
- Requests are never pipelined. Minimum transfer is IDLE→SETUP→ACCESS→RESP, giving rsp_valid 3 cycles after the accept edge with zero wait states.
- PWRITE/PADDR/PWDATA hold their last values in IDLE/RESP; PSEL=0 marks them don't-care.
- req_valid changes outside IDLE are ignored. A requester that drops req_valid before req_ready is still served once accepted.
- Simultaneous requests: exactly one grant per arbitration. All other requesters keep waiting, and their fields must stay stable.
- With a single active requester, back-to-back transfers are served every 4 cycles.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - On reaching TIMEOUT_CYC, abort: go to RESP with rsp_err=1 and rsp_rdata=0; PSEL/PENABLE drop in that cycle.
  - A PREADY arriving in the same cycle the count reaches TIMEOUT_CYC wins: a normal completion.
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

Decomposition:
- Package apb_arb_pkg:
  - state enum (IDLE, SETUP, ACCESS, RESP)
  - default widths ADDR_W_DEF=8, DATA_W_DEF=32
  - REG_SPACE_BYTES=16
- Sub-module apb_rr_arbiter: combinational round-robin pick (req vector + pointer → one-hot grant + index).
- The parent owns the pointer register and the FSM.

Test Plan:
- Single write, req0 addr=0x4 wdata=0xDEADBEEF, PREADY tied 1:
  - req_ready[0] on the SETUP cycle; PSEL/PENABLE follow 1/0 then 1/1.
  - rsp_valid[0] 3 cycles after accept with rsp_err=0.
  - A follow-up read of 0x4 returns 0xDEADBEEF.
- req0 and req1 both valid from reset, reads of 0x0 and 0x8:
  - Grants go 0,1,0,1 over four back-to-back transfers, with no double grant.
- Misaligned addr=0x6 and out-of-range addr=0x10:
  - No PSEL; rsp_err=1 and rsp_rdata=0 one cycle after accept.
- Slave holds PREADY=0 for 5 cycles:
  - ACCESS is held 6 cycles with PADDR/PWDATA stable.
  - PSLVERR=1 at completion gives rsp_err=1.
- PRESET asserted during ACCESS:
  - All outputs 0 immediately; no rsp_valid.
  - After release, requester 0 wins the first arbitration.
- APB_TIMEOUT_EN with TIMEOUT_CYC=16, PREADY stuck 0:
  - After 16 ACCESS cycles, rsp_err=1 and PSEL drops.
  - Without the macro, PSEL stays high indefinitely.
